// File: rtl/counter_pkg.sv
// Shared types and constants for the prescaled up/down counter.
package counter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int LED_W = 10;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled run cycles down to one tick every PRESCALE cycles.
// The phase holds whenever run is low, so a stopped counter resumes mid-phase.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic CLOCK,
  input  logic RESETn,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign tick = run && (phase == LAST);

  // Phase counter: clear wins, wraps on tick, advances on other run cycles.
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn)          phase <= '0;
    else if (clr || tick) phase <= '0;
    else if (run)         phase <= phase + PW'(1);
  end

endmodule

// File: rtl/prescaled_counter.sv
// Prescaled up/down counter with parallel load, start/stop/one-shot FSM,
// 10-bit LED window and registered terminal-count pulse.
// Optional macro PRESCALED_COUNTER_WRAPS_EN adds WRAPS, a saturating count
// of TC pulses cleared by reset and LOAD.
// EN low freezes the whole block: count, prescaler, state and LOAD/START/STOP.
module prescaled_counter
  import counter_pkg::*;
#(
  parameter int          N        = 24,
  parameter int unsigned MODULUS  = 0,
  parameter int          PRESCALE = 1,
  parameter int          LED_MSB  = N - 1
) (
  input  logic             CLOCK,
  input  logic             RESETn,
  input  logic             EN,
  input  logic             UP,
  input  logic             ONESHOT,
  input  logic             START,
  input  logic             STOP,
  input  logic             LOAD,
  input  logic [N-1:0]     LOAD_VAL,
  output logic [N-1:0]     COUNT,
  output logic [LED_W-1:0] LEDR,
  output logic             TC,
  output logic             DONE
`ifdef PRESCALED_COUNTER_WRAPS_EN
  ,
  output logic [7:0]       WRAPS
`endif
);

  localparam logic [N-1:0] MAX = (MODULUS == 0) ? {N{1'b1}} : N'(MODULUS - 1);

  state_t       state, state_nx;
  logic [N-1:0] count_nx, step, term;
  logic         tc_nx, at_wrap, tick, run, clr;

  // Prescaler only runs while counting; a stop request freezes its phase.
  assign run = EN && (state == S_RUN) && !LOAD && !STOP;
  assign clr = EN && (LOAD || (START && !STOP && (state == S_DONE)));

  tick_prescaler #(.PRESCALE(PRESCALE)) u_psc (
    .CLOCK (CLOCK),
    .RESETn(RESETn),
    .run   (run),
    .clr   (clr),
    .tick  (tick)
  );

  assign term    = UP ? MAX : '0;
  assign at_wrap = UP ? (COUNT == MAX) : (COUNT == '0);
  assign step    = UP ? (at_wrap ? '0 : COUNT + N'(1))
                      : (at_wrap ? MAX : COUNT - N'(1));

  // Next state/count: LOAD > STOP > START > tick, all gated by EN.
  always_comb begin
    state_nx = state;
    count_nx = COUNT;
    tc_nx    = 1'b0;
    if (EN) begin
      if (LOAD) begin
        count_nx = (LOAD_VAL > MAX) ? MAX : LOAD_VAL;
        if (STOP)                          state_nx = S_IDLE;
        else if (START && state != S_RUN)  state_nx = S_RUN;
        else if (state == S_DONE)          state_nx = S_IDLE;
      end else if (STOP) begin
        state_nx = S_IDLE;
      end else if (START && state != S_RUN) begin
        state_nx = S_RUN;
        // Restarting after a one-shot run begins from the start value.
        if (state == S_DONE) count_nx = UP ? '0 : MAX;
      end else if (tick) begin
        count_nx = step;
        if (ONESHOT) begin
          if (step == term) begin
            state_nx = S_DONE;
            tc_nx    = 1'b1;
          end
        end else begin
          tc_nx = at_wrap;
        end
      end
    end
  end

  // State, count and terminal-count pulse registers.
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state <= S_IDLE;
      COUNT <= '0;
      TC    <= 1'b0;
    end else begin
      state <= state_nx;
      COUNT <= count_nx;
      TC    <= tc_nx;
    end
  end

  assign LEDR = COUNT[LED_MSB -: LED_W];
  assign DONE = (state == S_DONE);

`ifdef PRESCALED_COUNTER_WRAPS_EN
  // Saturating TC pulse counter.
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn)                   WRAPS <= '0;
    else if (EN && LOAD)           WRAPS <= '0;
    else if (TC && WRAPS != 8'hFF) WRAPS <= WRAPS + 8'd1;
  end
`endif

endmodule
